// File: rtl/sobel_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sobel_param_pkg
// Description : Shared types and constants for the key-locked Sobel engine.
// Revision    : 1.0
// ============================================================================
package sobel_param_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_FETCH = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef logic signed [2:0] coef_t;

    // Taps are numbered row-major over the 3x3 window; GY is the transpose of GX.
    localparam coef_t c_gx_coef [0:8] = '{-3'sd1, 3'sd0, 3'sd1,
                                          -3'sd2, 3'sd0, 3'sd2,
                                          -3'sd1, 3'sd0, 3'sd1};
    localparam coef_t c_gy_coef [0:8] = '{-3'sd1, -3'sd2, -3'sd1,
                                           3'sd0,  3'sd0,  3'sd0,
                                           3'sd1,  3'sd2,  3'sd1};

    localparam logic       c_mode_sum    = 1'b0;
    localparam logic       c_mode_legacy = 1'b1;
    localparam logic [7:0] c_decoy_xor   = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/sobel_mag.sv
`default_nettype none
// ============================================================================
// Module      : sobel_mag
// Description : Output pixel from gradient pair, mode and border flag.
// Revision    : 1.0
// ============================================================================
module sobel_mag
    import sobel_param_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic signed [PIX_W+3:0] gx_i,
    input  logic signed [PIX_W+3:0] gy_i,
    input  logic                    mode_i,
    input  logic                    border_i,
    output logic        [PIX_W-1:0] mag_o
);
    localparam int ACC_W = PIX_W + 4;
    localparam logic [PIX_W-1:0] c_max = '1;

    logic [ACC_W-1:0] w_abs_x;
    logic [ACC_W-1:0] w_abs_y;
    logic [ACC_W:0]   w_sum_abs;
    logic [PIX_W-1:0] w_clamp_x;
    logic [PIX_W-1:0] w_clamp_y;
    logic [PIX_W-1:0] w_sum_clamp;

    always_comb begin
        w_abs_x   = gx_i[ACC_W-1] ? $unsigned(-gx_i) : $unsigned(gx_i);
        w_abs_y   = gy_i[ACC_W-1] ? $unsigned(-gy_i) : $unsigned(gy_i);
        w_sum_abs = {1'b0, w_abs_x} + {1'b0, w_abs_y};

        // Clamp to [0, max]: negatives drop to 0, anything with high bits set saturates.
        if (gx_i[ACC_W-1])              w_clamp_x = '0;
        else if (|gx_i[ACC_W-2:PIX_W])  w_clamp_x = c_max;
        else                            w_clamp_x = gx_i[PIX_W-1:0];
        if (gy_i[ACC_W-1])              w_clamp_y = '0;
        else if (|gy_i[ACC_W-2:PIX_W])  w_clamp_y = c_max;
        else                            w_clamp_y = gy_i[PIX_W-1:0];
        w_sum_clamp = w_clamp_x + w_clamp_y;

        if (border_i)
            mag_o = (mode_i == c_mode_legacy) ? c_max : '0;
        else if (mode_i == c_mode_legacy)
            mag_o = ~w_sum_clamp;
        else if (|w_sum_abs[ACC_W:PIX_W])
            mag_o = c_max;
        else
            mag_o = w_sum_abs[PIX_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/sobel_param_obf.sv
`default_nettype none
// ============================================================================
// Module      : sobel_param_obf
// Description : Key-locked raster Sobel filter, ROM in / RAM out, ap_ctrl_hs.
// Revision    : 1.0
// ============================================================================
module sobel_param_obf
    import sobel_param_pkg::*;
#(
    parameter int                IMG_W       = 512,
    parameter int                IMG_H       = 512,
    parameter int                PIX_W       = 8,
    parameter int                ADDR_W      = 18,
    parameter int                KEY_W       = 4,
    parameter logic [KEY_W-1:0]  CORRECT_KEY = 4'b1011
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic              mode,
    input  logic [KEY_W-1:0]  working_key,
    output logic [ADDR_W-1:0] indata_address0,
    output logic              indata_ce0,
    input  logic [PIX_W-1:0]  indata_q0,
    output logic [ADDR_W-1:0] outdata_address0,
    output logic              outdata_ce0,
    output logic              outdata_we0,
    output logic [PIX_W-1:0]  outdata_d0
);
    localparam int ACC_W = PIX_W + 4;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);

    state_t                   state_q;
    logic [XW-1:0]            x_q;
    logic [YW-1:0]            y_q;
    logic [ADDR_W-1:0]        pix_addr_q;
    logic [3:0]               tap_q;
    logic                     mode_q;
    logic signed [ACC_W-1:0]  gx_q, gx_d;
    logic signed [ACC_W-1:0]  gy_q, gy_d;

    logic [KEY_W-1:0]         w_key_ok;
    logic                     w_border;
    logic                     w_last_pix;
    logic [3:0]               w_last_tap;
    logic [3:0]               w_acc_tap;
    logic signed [ACC_W-1:0]  w_pix;
    logic signed [ACC_W-1:0]  w_cx;
    logic signed [ACC_W-1:0]  w_cy;
    logic [PIX_W-1:0]         w_mag;

    function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [3:0]        t);
        logic [ADDR_W-1:0] a;
        case (t)
            4'd0, 4'd1, 4'd2: a = base - ADDR_W'(IMG_W);
            4'd3, 4'd4, 4'd5: a = base;
            default:          a = base + ADDR_W'(IMG_W);
        endcase
        case (t)
            4'd0, 4'd3, 4'd6: a = a - ADDR_W'(1);
            4'd2, 4'd5, 4'd8: a = a + ADDR_W'(1);
            default:          a = a;
        endcase
        return a;
    endfunction

    assign ap_idle = (state_q == S_IDLE) && !ap_start;

    // Each key bit enables the genuine transition it guards.
    assign w_key_ok   = ~(working_key ^ CORRECT_KEY);
    assign w_border   = (x_q == '0) || (y_q == '0) ||
                        (x_q == XW'(IMG_W - 1)) || (y_q == YW'(IMG_H - 1));
    assign w_last_pix = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));
    assign w_last_tap = w_key_ok[3] ? 4'd8 : 4'd7;

    // ROM data on indata_q0 belongs to the tap issued one cycle earlier.
    always_comb begin
        w_acc_tap = (state_q == S_FETCH) ? tap_q - 4'd1 : tap_q;
        w_pix     = $signed({4'b0000, indata_q0});
        w_cx      = ACC_W'(c_gx_coef[w_acc_tap]);
        w_cy      = ACC_W'(c_gy_coef[w_acc_tap]);
        gx_d      = gx_q;
        gy_d      = gy_q;
        if (state_q == S_SCAN) begin
            gx_d = '0;
            gy_d = '0;
        end else if ((state_q == S_FETCH && tap_q != 4'd0) || state_q == S_DRAIN) begin
            gx_d = gx_q + w_pix * w_cx;
            gy_d = gy_q + w_pix * w_cy;
        end
    end

    sobel_mag #(.PIX_W(PIX_W)) u_mag (
        .gx_i     (gx_d),
        .gy_i     (gy_d),
        .mode_i   (mode_q),
        .border_i (state_q == S_SCAN),
        .mag_o    (w_mag)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q          <= S_IDLE;
            x_q              <= '0;
            y_q              <= '0;
            pix_addr_q       <= '0;
            tap_q            <= '0;
            mode_q           <= 1'b0;
            gx_q             <= '0;
            gy_q             <= '0;
            ap_done          <= 1'b0;
            ap_ready         <= 1'b0;
            indata_address0  <= '0;
            indata_ce0       <= 1'b0;
            outdata_address0 <= '0;
            outdata_ce0      <= 1'b0;
            outdata_we0      <= 1'b0;
            outdata_d0       <= '0;
        end else begin
            gx_q             <= gx_d;
            gy_q             <= gy_d;
            ap_done          <= 1'b0;
            ap_ready         <= 1'b0;
            indata_address0  <= '0;
            indata_ce0       <= 1'b0;
            outdata_address0 <= '0;
            outdata_ce0      <= 1'b0;
            outdata_we0      <= 1'b0;
            outdata_d0       <= '0;
            case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        mode_q     <= mode;
                        x_q        <= '0;
                        y_q        <= '0;
                        pix_addr_q <= '0;
                        state_q    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_border || !w_key_ok[0]) begin
                        outdata_ce0      <= 1'b1;
                        outdata_we0      <= 1'b1;
                        outdata_address0 <= pix_addr_q;
                        outdata_d0       <= w_mag;
                        state_q          <= S_WRITE;
                    end else begin
                        tap_q           <= 4'd0;
                        indata_ce0      <= 1'b1;
                        indata_address0 <= tap_addr(pix_addr_q, 4'd0);
                        state_q         <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (tap_q == w_last_tap) begin
                        state_q <= S_DRAIN;
                    end else begin
                        tap_q           <= tap_q + 4'd1;
                        indata_ce0      <= 1'b1;
                        indata_address0 <= tap_addr(pix_addr_q, tap_q + 4'd1);
                    end
                end
                S_DRAIN: begin
                    outdata_ce0      <= 1'b1;
                    outdata_we0      <= 1'b1;
                    outdata_address0 <= pix_addr_q;
                    outdata_d0       <= w_key_ok[1] ? w_mag : (w_mag ^ PIX_W'(c_decoy_xor));
                    state_q          <= S_WRITE;
                end
                S_WRITE: begin
                    pix_addr_q <= pix_addr_q + ADDR_W'(1);
                    if (x_q == XW'(IMG_W - 1)) begin
                        x_q <= '0;
                        y_q <= y_q + YW'(1);
                    end else begin
                        x_q <= x_q + XW'(1);
                    end
                    if (!w_last_pix) begin
                        state_q <= S_SCAN;
                    end else if (w_key_ok[2]) begin
                        ap_done  <= 1'b1;
                        ap_ready <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sobel_param_obf.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_param_obf
// Description : Self-checking bench for sobel_param_obf on a 4x4 image.
// Revision    : 1.0
// ============================================================================
module tb_sobel_param_obf;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NP = W * H;

    logic       clk = 1'b0;
    logic       ap_rst = 1'b0;
    logic       ap_start = 1'b0;
    logic       ap_done, ap_idle, ap_ready;
    logic       mode = 1'b0;
    logic [3:0] working_key = 4'b1011;
    logic [3:0] indata_address0;
    logic       indata_ce0;
    logic [7:0] indata_q0 = 8'd0;
    logic [3:0] outdata_address0;
    logic       outdata_ce0, outdata_we0;
    logic [7:0] outdata_d0;

    logic [7:0] img     [NP];
    logic [7:0] out_mem [NP];
    int         out_stamp [NP];
    int         wr_total = 0;
    int         checks = 0;
    int         errors = 0;

    sobel_param_obf #(
        .IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(4), .KEY_W(4), .CORRECT_KEY(4'b1011)
    ) dut (
        .ap_clk           (clk),
        .ap_rst           (ap_rst),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_idle          (ap_idle),
        .ap_ready         (ap_ready),
        .mode             (mode),
        .working_key      (working_key),
        .indata_address0  (indata_address0),
        .indata_ce0       (indata_ce0),
        .indata_q0        (indata_q0),
        .outdata_address0 (outdata_address0),
        .outdata_ce0      (outdata_ce0),
        .outdata_we0      (outdata_we0),
        .outdata_d0       (outdata_d0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (indata_ce0) indata_q0 <= img[indata_address0];
        if (outdata_ce0 && outdata_we0) begin
            out_mem[outdata_address0]   <= outdata_d0;
            out_stamp[outdata_address0] <= wr_total + 1;
            wr_total                    <= wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: direct 3x3 convolution from the image, with the decoy rules applied.
    function automatic int ref_pixel(int x, int y, bit md, bit [3:0] bad);
        int gx, gy, v, cx, cy, ntap;
        gx = 0;
        gy = 0;
        if (x == 0 || y == 0 || x == W - 1 || y == H - 1 || bad[0]) begin
            v = md ? 255 : 0;
        end else begin
            ntap = bad[3] ? 8 : 9;
            for (int t = 0; t < ntap; t++) begin
                int r, c, p;
                r = t / 3;
                c = t % 3;
                p = int'(img[(y + r - 1) * W + x + c - 1]);
                gx += (c - 1) * ((r == 1) ? 2 : 1) * p;
                gy += (r - 1) * ((c == 1) ? 2 : 1) * p;
            end
            if (!md) begin
                v = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                if (v > 255) v = 255;
            end else begin
                cx = gx < 0 ? 0 : (gx > 255 ? 255 : gx);
                cy = gy < 0 ? 0 : (gy > 255 ? 255 : gy);
                v  = (~(cx + cy)) & 255;
            end
            if (bad[1]) v = v ^ 'hA5;
        end
        return v;
    endfunction

    function automatic int ref_cycles(bit [3:0] bad);
        int n = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (x == 0 || y == 0 || x == W - 1 || y == H - 1 || bad[0]) n += 2;
                else n += bad[3] ? 11 : 12;
        return n;
    endfunction

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < NP; i++) img[i] = v;
    endtask

    task automatic fill_step();
        for (int i = 0; i < NP; i++) img[i] = ((i % W) < 2) ? 8'd0 : 8'd255;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NP; i++) img[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic run_and_check(input string tag, input bit md, input bit [3:0] key, input bit poke);
        bit [3:0] bad;
        int       exp_pix [NP];
        int       base, end_n;
        bit       saw_done;
        bad = key ^ 4'b1011;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                exp_pix[y * W + x] = ref_pixel(x, y, md, bad);
        @(negedge clk);
        base        = wr_total;
        mode        = md;
        working_key = key;
        ap_start    = 1'b1;
        @(posedge clk);
        #1 ap_start = 1'b0;
        end_n    = 0;
        saw_done = 1'b0;
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk);
            #1;
            if (poke && n == 5) ap_start = 1'b1;
            if (poke && n == 6) ap_start = 1'b0;
            if (ap_done) begin
                saw_done = 1'b1;
                end_n    = n;
                break;
            end
            if (ap_idle) begin
                end_n = n;
                break;
            end
        end
        check({tag, ".cycles"}, end_n, ref_cycles(bad));
        check({tag, ".done_pulse"}, saw_done, !bad[2]);
        check({tag, ".ready_eq_done"}, ap_ready, saw_done);
        @(posedge clk);
        #1;
        check({tag, ".idle_after"}, ap_idle, 1'b1);
        check({tag, ".done_cleared"}, ap_done, 1'b0);
        check({tag, ".writes"}, wr_total - base, NP);
        for (int i = 0; i < NP; i++)
            check($sformatf("%s.pix%0d", tag, i),
                  (out_stamp[i] > base) ? {24'd0, out_mem[i]} : 32'hDEAD, exp_pix[i]);
    endtask

    initial begin
        int wc;
        for (int i = 0; i < NP; i++) begin
            out_mem[i]   = 8'd0;
            out_stamp[i] = 0;
        end
        #2 ap_rst = 1'b1;
        #1;
        check("rst.idle", ap_idle, 1'b1);
        check("rst.done", ap_done, 1'b0);
        check("rst.ready", ap_ready, 1'b0);
        check("rst.in_ce", indata_ce0, 1'b0);
        check("rst.out_we", outdata_we0, 1'b0);
        check("rst.out_d", outdata_d0, 8'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) ap_rst = 1'b0;
        repeat (2) @(posedge clk);

        fill_const(8'd100);
        run_and_check("const_m0", 1'b0, 4'b1011, 1'b0);
        fill_step();
        run_and_check("step_m0", 1'b0, 4'b1011, 1'b0);
        fill_const(8'd100);
        run_and_check("const_m1", 1'b1, 4'b1011, 1'b0);
        fill_step();
        run_and_check("key_bit0", 1'b0, 4'b1010, 1'b0);
        fill_rand();
        run_and_check("key_bit2", 1'b0, 4'b1111, 1'b0);
        fill_rand();
        run_and_check("key_bit1", 1'b1, 4'b1001, 1'b0);
        fill_rand();
        run_and_check("key_bit3", 1'b0, 4'b0011, 1'b0);

        // Abort a frame while pixel (1,1) is fetching its window.
        fill_step();
        @(negedge clk);
        mode        = 1'b0;
        working_key = 4'b1011;
        wc          = wr_total;
        ap_start    = 1'b1;
        @(posedge clk);
        #1 ap_start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("abort.in_fetch", indata_ce0, 1'b1);
        check("abort.writes_before", wr_total - wc, 5);
        ap_rst = 1'b1;
        #1;
        check("abort.in_ce", indata_ce0, 1'b0);
        check("abort.in_addr", indata_address0, 4'd0);
        check("abort.out_ce", outdata_ce0, 1'b0);
        check("abort.out_we", outdata_we0, 1'b0);
        check("abort.out_d", outdata_d0, 8'd0);
        check("abort.idle", ap_idle, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk) ap_rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort.no_more_writes", wr_total - wc, 5);
        check("abort.idle_after", ap_idle, 1'b1);
        run_and_check("step_after_rst", 1'b0, 4'b1011, 1'b0);

        for (int r = 0; r < 6; r++) begin
            fill_rand();
            run_and_check($sformatf("rand%0d", r), 1'($urandom_range(0, 1)),
                          (r < 2) ? 4'b1011 : 4'($urandom_range(0, 15)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sobel_param_obf.md
SOBEL_PARAM_OBF -- requirements
Module: sobel_param_obf

Interface
Parameters:
REQ-001 IMG_W, 512, image width in pixels (>=3).
REQ-002 IMG_H, 512, image height in pixels (>=3).
REQ-003 PIX_W, 8, pixel width in bits.
REQ-004 ADDR_W, 18, memory address width; IMG_W*IMG_H <= 2^ADDR_W.
REQ-005 KEY_W, 4, locking key width; fixed at 4.
REQ-006 CORRECT_KEY, 4'b1011, unlocking key value.

Ports:
REQ-007 ap_clk  in  1  sole clock, rising edge.
REQ-008 ap_rst  in  1  reset, asynchronous, active-high.
REQ-009 ap_start in 1; ap_done, ap_idle, ap_ready out 1: ap_ctrl_hs block handshake.
REQ-010 mode  in  1  0 = |gx|+|gy| saturated; 1 = legacy inverted clamped sum.
REQ-011 working_key  in  KEY_W  locking key, static during a frame.
REQ-012 indata_address0 out ADDR_W; indata_ce0 out 1; indata_q0 in PIX_W: source ROM, read latency 1 cycle.
REQ-013 outdata_address0 out ADDR_W; outdata_ce0, outdata_we0 out 1; outdata_d0 out PIX_W: result RAM write port.

Function
REQ-014 SHALL use states IDLE, SCAN, FETCH, DRAIN, WRITE, DONE.
REQ-015 IDLE: ap_idle=1 iff ap_start=0. ap_start=1 latches mode, clears y and x, and moves to SCAN.
REQ-016 Scan order SHALL be raster: x 0..IMG_W-1 inner, y 0..IMG_H-1 outer.
REQ-017 Pixel address SHALL be y*IMG_W+x, for both reads and writes.
REQ-018 SCAN (1 cycle) SHALL classify the pixel. Border (x or y at an edge) goes to WRITE. Interior goes to FETCH and clears gx/gy.
REQ-019 FETCH SHALL issue one tap per cycle, taps t=0..8 in row-major order of the 3x3 window. indata_ce0=1 only in FETCH.
REQ-020 Each tap's data SHALL be accumulated the cycle after it is issued, using fixed Sobel coefficients: GX rows (-1,0,1)(-2,0,2)(-1,0,1); GY = transpose.
REQ-021 DRAIN (1 cycle) SHALL accumulate the last tap. gx/gy SHALL be signed, PIX_W+4 bits wide, with no overflow possible.
REQ-022 WRITE (1 cycle) SHALL assert outdata_ce0=outdata_we0=1.
REQ-023 Border pixels SHALL write 0 in mode 0 and 2^PIX_W-1 in mode 1.
REQ-024 Mode 0 interior: d0 = min(|gx|+|gy|, 2^PIX_W-1).
REQ-025 Mode 1 interior: d0 = ~((clamp(gx,0,max)+clamp(gy,0,max)) mod 2^PIX_W).
REQ-026 WRITE SHALL advance x, wrapping x to 0 and incrementing y. The next state is SCAN, or DONE after pixel (IMG_W-1, IMG_H-1).
REQ-027 DONE (1 cycle) SHALL pulse ap_done=ap_ready=1 and return to IDLE.
REQ-028 Cycle cost SHALL be 2 per border pixel and 12 per interior pixel, with DONE in the cycle following the last WRITE.
REQ-029 ap_start asserted outside IDLE SHALL be ignored.
REQ-030 All memory control signals SHALL be 0 outside their states.
REQ-031 Locking: each key bit gates one transition. With working_key==CORRECT_KEY, REQ-014..030 hold exactly.
REQ-032 A mismatching key bit SHALL take its deterministic decoy transition, per REQ-033..036.
REQ-033 Bit 0 mismatch: SCAN sends interior pixels to WRITE as if border.
REQ-034 Bit 1 mismatch: DRAIN->WRITE writes d0 XOR 8'hA5 (low PIX_W bits).
REQ-035 Bit 2 mismatch: after the final WRITE, go to IDLE with no ap_done/ap_ready pulse.
REQ-036 Bit 3 mismatch: FETCH enters DRAIN after tap 7; tap 8 is omitted.

Reset
REQ-037 Asserting ap_rst at any time SHALL immediately force IDLE, clear x, y, gx, gy and latched mode, and drive all outputs to 0 except ap_idle (1 iff ap_start=0). Any frame in progress is abandoned with no further writes.
REQ-038 After reset deassertion, the first ap_start SHALL begin a complete new frame.

Structure
REQ-039 Package sobel_param_pkg SHALL hold the state enum, the GX/GY coefficient tables, the mode encodings and the decoy XOR constant.
REQ-040 Combinational sub-module sobel_mag SHALL compute REQ-023..025 from gx, gy, mode and the border flag.
REQ-041 Target size is 150-300 lines of RTL.

Verification (IMG_W=IMG_H=4, PIX_W=8, correct key unless stated)
REQ-042 Constant image 100, mode 0: all 16 outputs 0; ap_done 72 cycles after the start-accept cycle (12 border*2 + 4 interior*12 = 72).
REQ-043 Columns 0-1 = 0 and columns 2-3 = 255, mode 0: interior (1,1) gx=1020 -> 255; (2,1) gx=1020 -> 255; border outputs 0.
REQ-044 Constant image 100, mode 1: all 16 outputs 255.
REQ-045 Key 4'b1010 (bit 0 wrong), REQ-043 image: all outputs 0; ap_done 32 cycles after start-accept.
REQ-046 ap_rst pulsed mid-FETCH of pixel (1,1): outputs 0 on the same edge, no further writes. A subsequent start reproduces REQ-043 exactly.
REQ-047 Key 4'b1111 (bit 2 wrong): all 16 writes occur, no ap_done pulse, returns to IDLE (ap_idle=1).
